// File: rtl/nios2_oci_tb_pkg.sv
// Shared definitions for the Nios II OCI trace capture buffer:
// FSM state encodings, overflow counter width and a clog2 helper.
package nios2_oci_tb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int OVF_W = 16;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/nios2_oci_tb_fifo.sv
// First-word-fall-through FIFO with registered head outputs and synchronous clear.
// Caller guarantees push only when not full (or popping) and pop only when rd_valid.
module nios2_oci_tb_fifo
  import nios2_oci_tb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      pop,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic [clog2(DEPTH):0]     level,
  output logic                      full
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nx;
  logic [AW:0]      rd_ptr_nx;

  always_comb begin
    wr_ptr_nx = wr_ptr + (AW+1)'(push);
    rd_ptr_nx = rd_ptr + (AW+1)'(pop);
    level     = wr_ptr - rd_ptr;
    full      = (level == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // The head register is reloaded every cycle; a push into an emptying FIFO bypasses the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      rd_valid <= (wr_ptr_nx != rd_ptr_nx);
      rd_data  <= (push && (wr_ptr == rd_ptr_nx)) ? wr_data : mem[rd_ptr_nx[AW-1:0]];
    end
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Nios II OCI DCT trace capture: clamps/masks words, queues them, drains over valid/ready.
// Optional OCI_TRACE_CHECKSUM_EN enables the XOR checksum of popped words.
//
// state    | meaning
// ST_RUN   | capturing qualified DCT words
// ST_FLUSH | end of test requested, draining remaining words
// ST_DONE  | drained or aborted; terminal until reset
module nios2_oci_trace_capture
  import nios2_oci_tb_pkg::*;
#(
  parameter int SLICE_W = 3,
  parameter int SLOTS   = 10,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        dct_valid,
  input  logic [SLICE_W*SLOTS-1:0]    dct_buffer,
  input  logic [CNT_W-1:0]            dct_count,
  input  logic                        test_ending,
  input  logic                        test_has_ended,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*SLOTS-1:0]    out_data,
  output logic [CNT_W-1:0]            out_count,
  output logic [clog2(DEPTH):0]       level,
  output logic [OVF_W-1:0]            overflow_cnt,
  output logic                        drained,
  output logic [SLICE_W*SLOTS-1:0]    checksum
);

  localparam int DCT_W = SLICE_W * SLOTS;
  localparam int LVL_W = clog2(DEPTH) + 1;

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    count_c;
  logic [DCT_W-1:0]    data_m;
  logic                push_try;
  logic                push;
  logic                pop;
  logic                drop;
  logic                full;
  logic [DCT_W+CNT_W-1:0] rd_word;

  always_comb begin
    count_c = (dct_count > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : dct_count;
    data_m  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (i < int'(count_c)) data_m[i*SLICE_W +: SLICE_W] = dct_buffer[i*SLICE_W +: SLICE_W];
    end
  end

  // Abort overrides both push and pop in its cycle.
  always_comb begin
    pop      = out_valid && out_ready && !test_has_ended;
    push_try = (state == ST_RUN) && dct_valid && (dct_count != '0) && !test_has_ended;
    push     = push_try && (!full || pop);
    drop     = push_try && full && !pop;
  end

  nios2_oci_tb_fifo #(
    .WIDTH(DCT_W + CNT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (test_has_ended),
    .push    (push),
    .wr_data ({count_c, data_m}),
    .pop     (pop),
    .rd_valid(out_valid),
    .rd_data (rd_word),
    .level   (level),
    .full    (full)
  );

  assign out_data  = rd_word[DCT_W-1:0];
  assign out_count = rd_word[DCT_W +: CNT_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:   if (test_ending) state_nx = ST_FLUSH;
      ST_FLUSH: if ((level == '0) || ((level == LVL_W'(1)) && pop)) state_nx = ST_DONE;
      default:  state_nx = ST_DONE;
    endcase
    if (test_has_ended) state_nx = ST_DONE;
  end

  always_comb begin
    drained = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         overflow_cnt <= '0;
    else if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
  end

`ifdef OCI_TRACE_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) checksum <= '0;
    else if (pop) checksum <= checksum ^ out_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed self-checking bench for nios2_oci_trace_capture at default parameters.
module tb_nios2_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic [4:0]  level;
  logic [15:0] overflow_cnt;
  logic        drained;
  logic [29:0] checksum;

  int          checks = 0;
  int          passes = 0;
  logic [29:0] exp_ck;

  always #5 clk = ~clk;

  nios2_oci_trace_capture dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dct_valid     (dct_valid),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .test_ending   (test_ending),
    .test_has_ended(test_has_ended),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_count     (out_count),
    .level         (level),
    .overflow_cnt  (overflow_cnt),
    .drained       (drained),
    .checksum      (checksum)
  );

  function automatic logic [29:0] ck_expected();
`ifdef OCI_TRACE_CHECKSUM_EN
    return exp_ck;
`else
    return 30'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    dct_valid      = 1'b0;
    dct_buffer     = '0;
    dct_count      = '0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    out_ready      = 1'b0;
    exp_ck         = '0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [29:0] b, input logic [3:0] c);
    dct_valid  = 1'b1;
    dct_buffer = b;
    dct_count  = c;
    tick();
    dct_valid  = 1'b0;
    dct_buffer = '0;
    dct_count  = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; out_ready = 1'b0; exp_ck = '0;
    #3;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 30'h0) $display("FAIL rst_out_data: got %h expected 0", out_data); else passes++;
    checks++; if (out_count !== 4'h0) $display("FAIL rst_out_count: got %0d expected 0", out_count); else passes++;
    checks++; if (level !== 5'd0) $display("FAIL rst_level: got %0d expected 0", level); else passes++;
    checks++; if (overflow_cnt !== 16'h0) $display("FAIL rst_overflow: got %0d expected 0", overflow_cnt); else passes++;
    checks++; if (drained !== 1'b0) $display("FAIL rst_drained: got %b expected 0", drained); else passes++;
    checks++; if (checksum !== 30'h0) $display("FAIL rst_checksum: got %h expected 0", checksum); else passes++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_push();
    do_reset();
    push_word(30'h3FFF_FFFF, 4'd3);
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_count !== 4'd3) $display("FAIL basic_count: got %0d expected 3", out_count); else passes++;
    checks++; if (out_data !== 30'h1FF) $display("FAIL basic_data: got %h expected 1ff", out_data); else passes++;
    checks++; if (level !== 5'd1) $display("FAIL basic_level: got %0d expected 1", level); else passes++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ck ^= 30'h1FF;
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_pop_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (checksum !== ck_expected()) $display("FAIL basic_checksum: got %h expected %h", checksum, ck_expected()); else passes++;
  endtask

  task automatic test_count_clamp();
    do_reset();
    push_word(30'h1234_5678, 4'd0);
    checks++; if (level !== 5'd0) $display("FAIL clamp_zero_level: got %0d expected 0", level); else passes++;
    checks++; if (overflow_cnt !== 16'h0) $display("FAIL clamp_zero_ovf: got %0d expected 0", overflow_cnt); else passes++;
    push_word(30'h2AAA_AAAA, 4'd15);
    push_word(30'h3FFF_FFFF, 4'd5);
    checks++; if (out_count !== 4'd10) $display("FAIL clamp_count: got %0d expected 10", out_count); else passes++;
    checks++; if (out_data !== 30'h2AAA_AAAA) $display("FAIL clamp_data: got %h expected 2aaaaaaa", out_data); else passes++;
    checks++; if (level !== 5'd2) $display("FAIL clamp_level: got %0d expected 2", level); else passes++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ck ^= 30'h2AAA_AAAA;
    checks++; if (out_data !== 30'h7FFF) $display("FAIL mask5_data: got %h expected 7fff", out_data); else passes++;
    checks++; if (out_count !== 4'd5) $display("FAIL mask5_count: got %0d expected 5", out_count); else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) push_word(30'(i + 1), 4'd10);
    checks++; if (level !== 5'd16) $display("FAIL ovf_level: got %0d expected 16", level); else passes++;
    checks++; if (overflow_cnt !== 16'd2) $display("FAIL ovf_count: got %0d expected 2", overflow_cnt); else passes++;
    checks++; if (out_data !== 30'h1) $display("FAIL ovf_head_stable: got %h expected 1", out_data); else passes++;
    out_ready = 1'b1;
    push_word(30'h123, 4'd10);
    out_ready = 1'b0;
    exp_ck ^= 30'h1;
    checks++; if (level !== 5'd16) $display("FAIL full_pushpop_level: got %0d expected 16", level); else passes++;
    checks++; if (overflow_cnt !== 16'd2) $display("FAIL full_pushpop_ovf: got %0d expected 2", overflow_cnt); else passes++;
    checks++; if (out_data !== 30'h2) $display("FAIL full_pushpop_head: got %h expected 2", out_data); else passes++;
    checks++; if (checksum !== ck_expected()) $display("FAIL ovf_checksum: got %h expected %h", checksum, ck_expected()); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) push_word(30'h10 + 30'(i), 4'd10);
    checks++; if (level !== 5'd5) $display("FAIL flush_fill_level: got %0d expected 5", level); else passes++;
    test_ending = 1'b1;
    out_ready   = 1'b1;
    tick();
    test_ending = 1'b0;
    exp_ck ^= 30'h10;
    for (int k = 1; k < 5; k++) begin
      checks++; if (out_data !== 30'h10 + 30'(k)) $display("FAIL flush_order: got %h expected %h", out_data, 30'h10 + 30'(k)); else passes++;
      checks++; if (drained !== 1'b0) $display("FAIL flush_early_drained: got %b expected 0", drained); else passes++;
      tick();
      exp_ck ^= 30'h10 + 30'(k);
    end
    out_ready = 1'b0;
    checks++; if (drained !== 1'b1) $display("FAIL flush_drained: got %b expected 1", drained); else passes++;
    checks++; if (level !== 5'd0) $display("FAIL flush_level: got %0d expected 0", level); else passes++;
    checks++; if (checksum !== ck_expected()) $display("FAIL flush_checksum: got %h expected %h", checksum, ck_expected()); else passes++;
    push_word(30'h3AB, 4'd10);
    checks++; if (level !== 5'd0) $display("FAIL done_push_level: got %0d expected 0", level); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL done_push_valid: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 7; i++) push_word(30'h100 + 30'(i), 4'd10);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    exp_ck ^= 30'h100 ^ 30'h101;
    checks++; if (level !== 5'd5) $display("FAIL abort_pre_level: got %0d expected 5", level); else passes++;
    test_has_ended = 1'b1;
    out_ready      = 1'b1;
    tick();
    test_has_ended = 1'b0;
    out_ready      = 1'b0;
    checks++; if (level !== 5'd0) $display("FAIL abort_level: got %0d expected 0", level); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (drained !== 1'b1) $display("FAIL abort_drained: got %b expected 1", drained); else passes++;
    checks++; if (checksum !== ck_expected()) $display("FAIL abort_checksum: got %h expected %h", checksum, ck_expected()); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(30'h200 + 30'(i), 4'd10);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    checks++; if (level !== 5'd4) $display("FAIL areset_pre_level: got %0d expected 4", level); else passes++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (level !== 5'd0) $display("FAIL areset_level: got %0d expected 0", level); else passes++;
    checks++; if (out_data !== 30'h0) $display("FAIL areset_data: got %h expected 0", out_data); else passes++;
    checks++; if (drained !== 1'b0) $display("FAIL areset_drained: got %b expected 0", drained); else passes++;
    #1;
    reset_n = 1'b1;
    tick();
    push_word(30'h3F, 4'd2);
    checks++; if (level !== 5'd1) $display("FAIL areset_run_level: got %0d expected 1", level); else passes++;
    checks++; if (out_data !== 30'h3F) $display("FAIL areset_run_data: got %h expected 3f", out_data); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_count_clamp();
    test_overflow();
    test_flush();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nios2_oci_trace_capture.md
# nios2_oci_trace_capture

Parametrised capture buffer for the Nios II OCI debug-trace (DCT) stream in the simulation/test-bench layer of the CPU subsystem. It samples qualified DCT words (packed slices plus a valid-slice count), queues them in a FIFO, and drains them to a consumer over a valid/ready port. End-of-test is handled by a flush-then-done sequence, and dropped words are counted. It generalises the fixed 30-bit/4-bit DCT observer to configurable slice width, slot count and depth.

## Interface
- SLICE_W, 3, bits per trace slice
- SLOTS, 10, slices per DCT word; DCT_W = SLICE_W*SLOTS
- CNT_W, 4, width of dct_count; must satisfy 2**CNT_W > SLOTS
- DEPTH, 16, FIFO entries, power of two, at least 2
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dct_valid  in  1  dct_buffer/dct_count qualified this cycle
- dct_buffer  in  DCT_W  packed slices; slot 0 in the LSBs
- dct_count  in  CNT_W  number of valid slots
- test_ending  in  1  begin graceful end-of-test (level, sampled)
- test_has_ended  in  1  abort: discard queue, go to DONE
- out_valid  out  1  out_data/out_count hold a queued word
- out_ready  in  1  consumer accepts the word when out_valid is also high
- out_data  out  DCT_W  queued slices; invalid slots forced to 0
- out_count  out  CNT_W  valid slots in out_data
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow_cnt  out  16  words dropped because the FIFO was full; saturating
- drained  out  1  high in DONE
- checksum  out  DCT_W  XOR of all popped out_data (see Configuration)

## Operation
- States: RUN (reset), FLUSH, DONE. Encoding is 2 bits.
- Push condition: state==RUN && dct_valid && dct_count!=0. A count of 0 is ignored and not counted.
- Count clamp: a dct_count greater than SLOTS is stored as SLOTS. Slots at index count and above are zeroed before storage.
- Full on a push attempt: if a pop occurs in the same cycle, the push is accepted. Otherwise the word is dropped and overflow_cnt increments, saturating at 16'hFFFF.
- Pop occurs when out_valid && out_ready. It is permitted in all states.
- RUN to FLUSH when test_ending=1. A push presented in that same cycle is still accepted.
- FLUSH to DONE in the cycle a pop leaves level==0, or immediately if the FIFO is already empty.
- Any state to DONE when test_has_ended=1. The FIFO is cleared the next cycle, so level=0 and out_valid=0. This takes priority over test_ending and over push/pop in that cycle.
- DONE is terminal until reset. In DONE, pushes are ignored and not counted.

## Timing
- Reset values: out_valid=0, out_data=0, out_count=0, level=0, overflow_cnt=0, drained=0, checksum=0, state=RUN.
- FWFT FIFO with registered outputs. A push to an empty FIFO in cycle N gives out_valid=1 in cycle N+1.
- level updates one cycle after a push or pop. A simultaneous push and pop leaves level unchanged.
- Pointer wrap is modulo DEPTH. An extra MSB distinguishes full from empty.
- drained rises one cycle after the terminating pop, or after the abort sample.
- reset_n asserted mid-operation: all outputs go to their reset values asynchronously; FIFO contents are lost.
- out_data/out_count are stable while out_valid && !out_ready.

## Configuration
- OCI_TRACE_CHECKSUM_EN defined: checksum ^= out_data on every pop. Cleared only by reset; an abort does not clear it.
- OCI_TRACE_CHECKSUM_EN undefined: checksum is tied to 0 and no checksum register is generated. The port remains present.

## Structure
- Shared package/include nios2_oci_tb_pkg:
  - state encodings RUN/FLUSH/DONE
  - overflow counter width (16)
  - a clog2 helper
- One sub-module: nios2_oci_tb_fifo
  - parametrised WIDTH/DEPTH, synchronous clear, FWFT
  - holds {count, data}
- Top level holds the FSM, clamp/mask logic, overflow counter and checksum.

## Test plan
- Defaults; push count=3 with buffer=30'h3FFF_FFFF -> next cycle out_valid=1, out_count=3, out_data=30'h1FF.
- Push count=0 then count=15 -> first is ignored; second is stored as count=10, data unmasked.
- out_ready=0, 18 pushes -> level=16, overflow_cnt=2. A push with a simultaneous pop when full -> accepted, level stays 16.
- 5 queued words, test_ending pulse, out_ready=1 -> 5 pops; drained=1 one cycle after the last pop; later dct_valid pushes are ignored.
- 7 queued words, test_has_ended -> next cycle level=0, out_valid=0, drained=1. Checksum with the macro defined equals the XOR of words popped before the abort; with the macro undefined it is 0.
- reset_n low mid-FLUSH with 4 queued -> all outputs at reset values; state RUN after release.
